// File: rtl/ctrl_pulse_gen.sv
// Multi-channel pulse/PWM generator with shadowed configuration and one-shot support.
// Optional done output is enabled by defining CTRL_PULSE_GEN_DONE_EN.
//
// state  | meaning
// S_IDLE | channel stopped, ctrl low, active config tracks shadow every cycle
// S_RUN  | counting 0..period-1, ctrl high while cnt < high
module ctrl_pulse_gen #(
  parameter  int CH    = 4,
  parameter  int CNT_W = 16,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_oneshot,
  input  logic [CH-1:0]    start,
  input  logic [CH-1:0]    stop,
  output logic [CH-1:0]    ctrl,
  output logic [CH-1:0]    busy
`ifdef CTRL_PULSE_GEN_DONE_EN
  ,
  output logic [CH-1:0]    done
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_per, r_high, r_sh_per, r_sh_high;
    logic [CNT_W-1:0] w_per_eff;
    logic             r_os, r_sh_os;
    logic             r_ctrl, w_ctrl_nxt;
    logic             w_sh_we, w_wrap, w_load;

    assign w_sh_we   = cfg_we && (cfg_ch == CH_W'(g));
    assign w_per_eff = (r_per == '0) ? CNT_W'(1) : r_per;
    assign w_wrap    = (r_cnt == w_per_eff - CNT_W'(1));
    // Active config only changes at a period boundary so a running waveform never glitches.
    assign w_load    = (r_state == S_IDLE) || w_wrap;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_ctrl    <= 1'b0;
        r_per     <= '0;
        r_high    <= '0;
        r_os      <= 1'b0;
        r_sh_per  <= '0;
        r_sh_high <= '0;
        r_sh_os   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_ctrl  <= w_ctrl_nxt;
        if (w_sh_we) begin
          r_sh_per  <= cfg_period;
          r_sh_high <= cfg_high;
          r_sh_os   <= cfg_oneshot;
        end
        if (w_load) begin
          r_per  <= r_sh_per;
          r_high <= r_sh_high;
          r_os   <= r_sh_os;
        end
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_IDLE) begin
        if (start[g] && !stop[g]) w_state_nxt = S_RUN;
      end else begin
        if (stop[g] || (w_wrap && r_os)) w_state_nxt = S_IDLE;
      end
    end

    always_comb begin
      w_cnt_nxt  = '0;
      w_ctrl_nxt = 1'b0;
      if (r_state == S_RUN && !stop[g]) begin
        w_ctrl_nxt = (r_cnt < r_high);
        w_cnt_nxt  = w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
    end

    assign ctrl[g] = r_ctrl;
    assign busy[g] = (r_state == S_RUN);

`ifdef CTRL_PULSE_GEN_DONE_EN
    logic r_done, w_done_nxt;

    // Only a natural one-shot wrap completes; stop on the wrap cycle suppresses it.
    always_comb begin
      w_done_nxt = (r_state == S_RUN) && !stop[g] && w_wrap && r_os;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_done <= 1'b0;
      else     r_done <= w_done_nxt;
    end

    assign done[g] = r_done;
`endif
  end

endmodule

// File: tb/tb_ctrl_pulse_gen.sv
// Directed self-checking bench for ctrl_pulse_gen (CH=4, CNT_W=16).
// Done checks are compiled in when CTRL_PULSE_GEN_DONE_EN is defined.
module tb_ctrl_pulse_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic        cfg_oneshot = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  stop = '0;
  logic [3:0]  ctrl;
  logic [3:0]  busy;
`ifdef CTRL_PULSE_GEN_DONE_EN
  logic [3:0]  done;
`endif

  int total = 0;
  int bad   = 0;

  ctrl_pulse_gen #(.CH(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .cfg_oneshot(cfg_oneshot),
    .start(start),
    .stop(stop),
    .ctrl(ctrl),
    .busy(busy)
`ifdef CTRL_PULSE_GEN_DONE_EN
    ,
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int per, input int hi, input bit os);
    cfg_ch      = 2'(ch);
    cfg_period  = 16'(per);
    cfg_high    = 16'(hi);
    cfg_oneshot = os;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 4'hF;
    tick();
    tick();
    total++; if (ctrl !== 4'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
`ifdef CTRL_PULSE_GEN_DONE_EN
    total++; if (done !== 4'h0) begin bad++; $display("FAIL reset_done got=%h exp=0", done); end
`endif
    rst   = 1'b0;
    start = 4'h0;
    tick();
    tick();
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL post_reset_idle got=%h exp=0", busy); end
  endtask

  task automatic test_continuous();
    logic e;
    cfg(0, 4, 2, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    total++; if (ctrl[0] !== 1'b0) begin bad++; $display("FAIL cont_latency got=%b exp=0", ctrl[0]); end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL cont_busy_rise got=%b exp=1", busy[0]); end
    for (int k = 0; k < 8; k++) begin
      if (k == 1) start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      e = ((k % 4) < 2);
      total++; if (ctrl[0] !== e) begin bad++; $display("FAIL cont_ctrl k=%0d got=%b exp=%b", k, ctrl[0], e); end
      total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL cont_busy k=%0d got=%b exp=1", k, busy[0]); end
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    total++; if (ctrl[0] !== 1'b0) begin bad++; $display("FAIL stop_ctrl got=%b exp=0", ctrl[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", busy[0]); end
    tick();
    total++; if (ctrl[0] !== 1'b0) begin bad++; $display("FAIL stop_hold got=%b exp=0", ctrl[0]); end
  endtask

  task automatic test_oneshot();
    logic ec, eb;
    cfg(1, 5, 3, 1'b1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL os_busy_rise got=%b exp=1", busy[1]); end
    for (int k = 0; k < 8; k++) begin
      tick();
      ec = (k < 3);
      eb = (k < 4);
      total++; if (ctrl[1] !== ec) begin bad++; $display("FAIL os_ctrl k=%0d got=%b exp=%b", k, ctrl[1], ec); end
      total++; if (busy[1] !== eb) begin bad++; $display("FAIL os_busy k=%0d got=%b exp=%b", k, busy[1], eb); end
      total++; if (ctrl[0] !== 1'b0) begin bad++; $display("FAIL os_ch0_quiet k=%0d got=%b exp=0", k, ctrl[0]); end
`ifdef CTRL_PULSE_GEN_DONE_EN
      total++; if (done[1] !== (k == 4)) begin bad++; $display("FAIL os_done k=%0d got=%b exp=%b", k, done[1], (k == 4)); end
`endif
    end
  endtask

  task automatic test_reconfig();
    logic [15:0] exp_seq;
    exp_seq = 16'b1000_111000_111000;
    cfg(0, 4, 1, 1'b0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        cfg_ch = 2'd0; cfg_period = 16'd6; cfg_high = 16'd3; cfg_oneshot = 1'b0; cfg_we = 1'b1;
      end
      tick();
      cfg_we = 1'b0;
      total++; if (ctrl[0] !== exp_seq[15-k]) begin bad++; $display("FAIL reconfig k=%0d got=%b exp=%b", k, ctrl[0], exp_seq[15-k]); end
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
  endtask

  task automatic test_edges();
    cfg(2, 4, 2, 1'b0);
    start[2] = 1'b1;
    stop[2]  = 1'b1;
    tick();
    start[2] = 1'b0;
    stop[2]  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (busy[2] !== 1'b0) begin bad++; $display("FAIL startstop_busy k=%0d got=%b exp=0", k, busy[2]); end
      total++; if (ctrl[2] !== 1'b0) begin bad++; $display("FAIL startstop_ctrl k=%0d got=%b exp=0", k, ctrl[2]); end
      tick();
    end
    cfg(2, 4, 0, 1'b0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (ctrl[2] !== 1'b0) begin bad++; $display("FAIL high0 k=%0d got=%b exp=0", k, ctrl[2]); end
      total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL high0_busy k=%0d got=%b exp=1", k, busy[2]); end
    end
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;
    cfg(3, 8, 9, 1'b0);
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (ctrl[3] !== 1'b1) begin bad++; $display("FAIL high_ge_per k=%0d got=%b exp=1", k, ctrl[3]); end
    end
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0;
    total++; if (ctrl[3] !== 1'b0) begin bad++; $display("FAIL high_ge_per_stop got=%b exp=0", ctrl[3]); end
    cfg(2, 0, 1, 1'b0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (ctrl[2] !== 1'b1) begin bad++; $display("FAIL per0 k=%0d got=%b exp=1", k, ctrl[2]); end
    end
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int per[4];
    int hi[4];
    logic [3:0] e;
    per = '{3, 4, 5, 6};
    hi  = '{1, 2, 2, 3};
    cfg(0, 3, 1, 1'b0);
    cfg(1, 4, 2, 1'b1);
    cfg(2, 5, 2, 1'b0);
    cfg(3, 6, 3, 1'b0);
    start = 4'hF;
    tick();
    start = 4'h0;
    tick();
    tick();
    tick();
    total++; if (busy !== 4'hF) begin bad++; $display("FAIL midrun_busy got=%h exp=f", busy); end
    #3 rst = 1'b1;
    #1;
    total++; if (ctrl !== 4'h0) begin bad++; $display("FAIL async_rst_ctrl got=%h exp=0", ctrl); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL async_rst_busy got=%h exp=0", busy); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (busy !== 4'h0) begin bad++; $display("FAIL rst_stay_idle k=%0d got=%h exp=0", k, busy); end
`ifdef CTRL_PULSE_GEN_DONE_EN
      total++; if (done !== 4'h0) begin bad++; $display("FAIL rst_no_done k=%0d got=%h exp=0", k, done); end
`endif
    end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (ctrl[0] !== 1'b0) begin bad++; $display("FAIL rst_cfg_cleared k=%0d got=%b exp=0", k, ctrl[0]); end
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    for (int c = 0; c < 4; c++) cfg(c, per[c], hi[c], 1'b0);
    start = 4'hF;
    tick();
    start = 4'h0;
    for (int k = 0; k < 12; k++) begin
      tick();
      for (int c = 0; c < 4; c++) e[c] = ((k % per[c]) < hi[c]);
      total++; if (ctrl !== e) begin bad++; $display("FAIL restart_ctrl k=%0d got=%h exp=%h", k, ctrl, e); end
    end
    stop = 4'hF;
    tick();
    stop = 4'h0;
    total++; if (ctrl !== 4'h0 || busy !== 4'h0) begin bad++; $display("FAIL final_stop got=%h/%h exp=0/0", ctrl, busy); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_reconfig();
    test_edges();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctrl_pulse_gen.md
CTRL_PULSE_GEN -- requirements
Module: ctrl_pulse_gen

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning the number of independent control channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the period and high-time counters.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic SHALL be rising-edge clk.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port cfg_we, input, 1 bit, a configuration write strobe.
REQ-006 The block SHALL have port cfg_ch, input, $clog2(CH) bits (min 1), the target channel of a configuration write.
REQ-007 The block SHALL have port cfg_period, input, CNT_W bits, the period in clk cycles.
REQ-008 The block SHALL have port cfg_high, input, CNT_W bits, the high time in clk cycles.
REQ-009 The block SHALL have port cfg_oneshot, input, 1 bit: 1 = one-shot, 0 = continuous.
REQ-010 The block SHALL have port start, input, CH bits, a per-channel start pulse.
REQ-011 The block SHALL have port stop, input, CH bits, a per-channel stop pulse.
REQ-012 The block SHALL have port ctrl, output, CH bits, the registered per-channel control waveform.
REQ-013 The block SHALL have port busy, output, CH bits, high while a channel is in RUN.
REQ-014 The block SHALL have port done, output, CH bits, a one-cycle end-of-one-shot pulse, present only per REQ-031.

Function
REQ-015 Each channel SHALL be a two-state FSM: IDLE, RUN.
REQ-016 Each channel SHALL hold active registers (period, high, oneshot) and a shadow copy.
REQ-017 cfg_we SHALL write the cfg_* values to the shadow registers of channel cfg_ch; cfg_ch >= CH SHALL be ignored.
REQ-018 In IDLE, the shadow registers SHALL copy to the active registers every cycle.
REQ-019 In RUN, the shadow registers SHALL copy to the active registers only on the wrap cycle (cnt == period-1), so there is no mid-period glitch.
REQ-020 A period of 0 SHALL be treated as 1.
REQ-021 Transitions:
- IDLE with start[i] sampled SHALL go to RUN with cnt = 0.
- In RUN, cnt SHALL increment and wrap to 0 after period-1.
REQ-022 ctrl[i] SHALL be 1 iff state == RUN and cnt < high.
- high = 0 SHALL give a constant low.
- high >= period SHALL give a constant high.
- ctrl SHALL be registered: start sampled at edge n gives ctrl valid for cnt = 0 after edge n+1 (one-cycle latency).
REQ-023 One-shot mode SHALL return to IDLE on the wrap cycle, driving ctrl low after that wrap cycle.
- Continuous mode SHALL repeat until stop.
REQ-024 stop[i] SHALL force IDLE on the next edge with ctrl[i] = 0 and cnt = 0, regardless of count position.
REQ-025 When start[i] and stop[i] are sampled in the same cycle, stop SHALL win.
REQ-026 start[i] in RUN SHALL be ignored; no restart occurs.
REQ-027 Channels SHALL be fully independent; simultaneous activity on all channels SHALL be supported.

Reset
REQ-028 rst high SHALL immediately put all channels in IDLE and force ctrl = 0, busy = 0, done = 0, cnt = 0.
REQ-029 rst high SHALL clear the active and shadow registers to period = 0, high = 0, oneshot = 0.
REQ-030 Reset asserted mid-RUN SHALL abort without a completion pulse.
- After deassertion, each channel SHALL remain IDLE until a new start.

Configuration
REQ-031 Macro CTRL_PULSE_GEN_DONE_EN gates the done output.
- Defined: the done port SHALL exist and pulse high for 1 cycle, coincident with the first IDLE cycle after a one-shot wrap.
- Defined: done SHALL NOT pulse on stop or reset.
- Undefined: the done port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 The bench SHALL cover these scenarios:
- ch0, period = 4, high = 2, continuous, start → ctrl[0] pattern 1100 repeating from the 2nd cycle after start; busy[0] = 1.
- ch1, period = 5, high = 3, one-shot, start → 11100 once, then IDLE; done[1] pulses once (with macro); busy[1] drops.
- ch0 running period = 4, high = 1; write period = 6, high = 3 mid-period → the current period completes as 1000, then 111000.
- start and stop on ch2 in the same cycle → ch2 stays IDLE, ctrl[2] = 0; edges: high = 0 → constant 0; high = 9, period = 8 → constant 1.
- All 4 channels started together with different periods, rst asserted mid-run → all outputs 0 asynchronously, no done; each channel restarts cleanly after a new start.
